// File: rtl/hazard_stall_controller_if.sv
// Pipeline hazard control bundle: IF/ID and ID/EX hazard sources in,
// stage enables/flushes and debug state out.
interface hazard_stall_controller_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] rs_ifid;
  logic [REG_ADDR_W-1:0] rt_ifid;
  logic                  uses_rs_ifid;
  logic                  uses_rt_ifid;
  logic                  mem_read_idex;
  logic [REG_ADDR_W-1:0] rf_waddr_idex;
  logic                  branch_taken_ex;
  logic                  mem_req_exmem;
  logic                  mem_ready;
  logic                  pc_wen;
  logic                  ifid_wen;
  logic                  idex_wen;
  logic                  exmem_wen;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic [1:0]            ctrl_state;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output rs_ifid, rt_ifid, uses_rs_ifid, uses_rt_ifid, mem_read_idex,
           rf_waddr_idex, branch_taken_ex, mem_req_exmem, mem_ready,
    input  pc_wen, ifid_wen, idex_wen, exmem_wen, ifid_flush, idex_flush,
           ctrl_state, stall_count
  );

  modport slave (
    input  rs_ifid, rt_ifid, uses_rs_ifid, uses_rt_ifid, mem_read_idex,
           rf_waddr_idex, branch_taken_ex, mem_req_exmem, mem_ready,
    output pc_wen, ifid_wen, idex_wen, exmem_wen, ifid_flush, idex_flush,
           ctrl_state, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: memory freeze > branch flush > load-use bubble,
// combinational controls from registered state, saturating stall counter.
module hazard_stall_controller #(
  parameter int REG_ADDR_W   = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  bus
);
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] FC_M1 = 4'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_flush_cnt;
  logic             r_br_pending;
  logic [CNT_W-1:0] r_stall_count;

  state_t     w_next_state;
  logic [3:0] w_next_cnt;
  logic       w_next_pending;
  logic       w_freeze, w_branch, w_in_flush, w_load_use, w_stall;
  logic       w_pc_wen, w_ifid_wen, w_idex_wen, w_exmem_wen;
  logic       w_ifid_flush, w_idex_flush;

  always_comb begin
    w_freeze   = (bus.mem_req_exmem && !bus.mem_ready) ||
                 (r_state == S_MEM_WAIT && !bus.mem_ready);
    w_branch   = !w_freeze && (bus.branch_taken_ex || r_br_pending);
    // a freeze that interrupted FLUSH keeps the counter, so MEM_WAIT releases back into it
    w_in_flush = !w_freeze && (r_state == S_FLUSH ||
                 (r_state == S_MEM_WAIT && r_flush_cnt != 4'd0));
    w_load_use = bus.mem_read_idex && (bus.rf_waddr_idex != REG_ADDR_W'(0)) &&
                 ((bus.uses_rs_ifid && bus.rs_ifid == bus.rf_waddr_idex) ||
                  (bus.uses_rt_ifid && bus.rt_ifid == bus.rf_waddr_idex));

    w_pc_wen       = 1'b1;
    w_ifid_wen     = 1'b1;
    w_idex_wen     = 1'b1;
    w_exmem_wen    = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_next_state   = S_RUN;
    w_next_cnt     = 4'd0;
    w_next_pending = 1'b0;

    if (w_freeze) begin
      w_pc_wen       = 1'b0;
      w_ifid_wen     = 1'b0;
      w_idex_wen     = 1'b0;
      w_exmem_wen    = 1'b0;
      w_next_state   = S_MEM_WAIT;
      w_next_cnt     = r_flush_cnt;
      w_next_pending = r_br_pending || bus.branch_taken_ex;
    end else if (w_branch) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_next_state = S_FLUSH;
        w_next_cnt   = FC_M1;
      end
    end else if (w_in_flush) begin
      w_ifid_flush = 1'b1;
      if (r_flush_cnt > 4'd1) begin
        w_next_state = S_FLUSH;
        w_next_cnt   = r_flush_cnt - 4'd1;
      end
    end else if (w_load_use) begin
      w_pc_wen     = 1'b0;
      w_ifid_wen   = 1'b0;
      w_idex_flush = 1'b1;
    end

    w_stall = !(w_pc_wen && w_ifid_wen && w_idex_wen && w_exmem_wen) ||
              w_ifid_flush || w_idex_flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_flush_cnt   <= 4'd0;
      r_br_pending  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_flush_cnt  <= w_next_cnt;
      r_br_pending <= w_next_pending;
      if (w_stall && r_stall_count != {CNT_W{1'b1}})
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign bus.pc_wen      = w_pc_wen     && !rst;
  assign bus.ifid_wen    = w_ifid_wen   && !rst;
  assign bus.idex_wen    = w_idex_wen   && !rst;
  assign bus.exmem_wen   = w_exmem_wen  && !rst;
  assign bus.ifid_flush  = w_ifid_flush && !rst;
  assign bus.idex_flush  = w_idex_flush && !rst;
  assign bus.ctrl_state  = r_state;
  assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table through a scoreboard queue,
// plus reset-abort and counter-saturation sequences.
module tb_hazard_stall_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_stall_controller_if #(.REG_ADDR_W(4), .CNT_W(16)) bus0 ();
  hazard_stall_controller_if #(.REG_ADDR_W(4), .CNT_W(3))  bus1 ();

  assign bus1.rs_ifid         = bus0.rs_ifid;
  assign bus1.rt_ifid         = bus0.rt_ifid;
  assign bus1.uses_rs_ifid    = bus0.uses_rs_ifid;
  assign bus1.uses_rt_ifid    = bus0.uses_rt_ifid;
  assign bus1.mem_read_idex   = bus0.mem_read_idex;
  assign bus1.rf_waddr_idex   = bus0.rf_waddr_idex;
  assign bus1.branch_taken_ex = bus0.branch_taken_ex;
  assign bus1.mem_req_exmem   = bus0.mem_req_exmem;
  assign bus1.mem_ready       = bus0.mem_ready;

  hazard_stall_controller #(.REG_ADDR_W(4), .FLUSH_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus0));
  hazard_stall_controller #(.REG_ADDR_W(4), .FLUSH_CYCLES(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [3:0]  rs, rt;
    logic        urs, urt, mrd;
    logic [3:0]  wa;
    logic        br, mreq, mrdy;
    logic [3:0]  e_wen;   // {pc, ifid, idex, exmem}
    logic [1:0]  e_fl;    // {ifid, idex}
    logic [1:0]  e_st;
    logic [15:0] e_cnt;
  } vec_t;

  logic [23:0] exp_q[$];
  vec_t        vecs[$];

  function automatic vec_t mk(logic [3:0] rs, logic [3:0] rt, logic urs, logic urt,
                              logic mrd, logic [3:0] wa, logic br, logic mreq, logic mrdy,
                              logic [3:0] wen, logic [1:0] fl, logic [1:0] st, logic [15:0] cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd; v.wa = wa;
    v.br = br; v.mreq = mreq; v.mrdy = mrdy;
    v.e_wen = wen; v.e_fl = fl; v.e_st = st; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic logic [23:0] obs();
    return {bus0.pc_wen, bus0.ifid_wen, bus0.idex_wen, bus0.exmem_wen,
            bus0.ifid_flush, bus0.idex_flush, bus0.ctrl_state, bus0.stall_count};
  endfunction

  task automatic check(string name, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got wen/fl/st/cnt=%h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus0.rs_ifid = v.rs; bus0.rt_ifid = v.rt;
    bus0.uses_rs_ifid = v.urs; bus0.uses_rt_ifid = v.urt;
    bus0.mem_read_idex = v.mrd; bus0.rf_waddr_idex = v.wa;
    bus0.branch_taken_ex = v.br; bus0.mem_req_exmem = v.mreq; bus0.mem_ready = v.mrdy;
  endtask

  // drive at negedge, push expectation, compare 1 time unit later (before posedge)
  task automatic step(string name, vec_t v);
    @(negedge clk);
    drive(v);
    exp_q.push_back({v.e_wen, v.e_fl, v.e_st, v.e_cnt});
    #1;
    check(name, obs(), exp_q.pop_front());
  endtask

  initial begin
    // rs rt urs urt mrd wa br mreq mrdy | wen fl st cnt
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0, 0));  // idle
    vecs.push_back(mk(3,0,1,0,1,3, 0,0,0, 4'b0011,2'b01,0, 0));  // load-use r3 on rs
    vecs.push_back(mk(1,0,1,0,0,0, 0,0,0, 4'b1111,2'b00,0, 1));
    vecs.push_back(mk(0,0,1,0,1,0, 0,0,0, 4'b1111,2'b00,0, 1));  // r0 never a hazard
    vecs.push_back(mk(2,5,1,0,1,5, 0,0,0, 4'b1111,2'b00,0, 1));  // rt match, unused
    vecs.push_back(mk(2,5,1,1,1,5, 0,0,0, 4'b0011,2'b01,0, 1));  // rt match, used
    vecs.push_back(mk(5,0,1,0,0,5, 0,0,0, 4'b1111,2'b00,0, 2));  // not a load
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0, 4'b1111,2'b11,0, 2));  // branch pulse
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1, 3));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1, 4));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0, 5));
    vecs.push_back(mk(3,0,1,0,1,3, 1,0,0, 4'b1111,2'b11,0, 5));  // branch beats load-use
    vecs.push_back(mk(3,0,1,0,1,3, 0,0,0, 4'b1111,2'b10,1, 6));  // no bubble in FLUSH
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0, 4'b1111,2'b11,1, 7));  // reload in FLUSH
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1, 8));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1, 9));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0,10));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,1, 4'b1111,2'b00,0,10));  // ready same cycle
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 4'b0000,2'b00,0,10));  // 4-cycle freeze
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 4'b0000,2'b00,2,11));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 4'b0000,2'b00,2,12));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 4'b0000,2'b00,2,13));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,1, 4'b1111,2'b00,2,14));  // release
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0,14));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0, 4'b0000,2'b00,0,14));  // branch under freeze
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0, 4'b0000,2'b00,2,15));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,1, 4'b1111,2'b11,2,16));  // flush on release
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1,17));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 4'b0000,2'b00,1,18));  // freeze mid-FLUSH
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,1, 4'b1111,2'b10,2,19));  // FLUSH resumes
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0,20));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0, 4'b0000,2'b00,0,20));  // branch only while frozen
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,1, 4'b1111,2'b11,2,21));  // pending branch applied
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1,22));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1,23));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0,24));

    // reset held with hazards on the inputs: everything must be gated off
    drive(mk(3,0,1,0,1,3, 1,1,0, 0,0,0,0));
    #3;
    check("reset_hold", obs(), 24'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0));

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    checks++;
    if (bus1.stall_count !== 3'b111) begin
      errors++;
      $display("FAIL sat_cnt: got %0d expected 7", bus1.stall_count);
    end

    // reset during FLUSH
    step("rstA_branch", mk(0,0,0,0,0,0, 1,0,0, 4'b1111,2'b11,0,24));
    step("rstA_flush",  mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b10,1,25));
    checks++;
    if ({bus1.ctrl_state, bus1.ifid_flush} !== 3'b000) begin
      errors++;
      $display("FAIL fc1_single: got st=%0d ifid_flush=%0b expected 0/0",
               bus1.ctrl_state, bus1.ifid_flush);
    end
    bus0.branch_taken_ex = 1'b1;
    #2 rst = 1'b1;
    #1 check("rstA_asserted", obs(), 24'h0);
    @(negedge clk);
    rst = 1'b0;
    bus0.branch_taken_ex = 1'b0;
    #1 check("rstA_release", obs(), {4'b1111, 2'b00, 2'd0, 16'd0});
    checks++;
    if (bus1.stall_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_sat_cnt: got %0d expected 0", bus1.stall_count);
    end
    step("rstA_after", mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0,0));

    // reset during MEM_WAIT
    step("rstB_freeze0", mk(0,0,0,0,0,0, 1,1,0, 4'b0000,2'b00,0,0));
    step("rstB_freeze1", mk(0,0,0,0,0,0, 1,1,0, 4'b0000,2'b00,2,1));
    #2 rst = 1'b1;
    #1 check("rstB_asserted", obs(), 24'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0));
    #1 check("rstB_release", obs(), {4'b1111, 2'b00, 2'd0, 16'd0});
    step("rstB_after", mk(0,0,0,0,0,0, 0,0,0, 4'b1111,2'b00,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
